// File: rtl/cr_sched_pkg.sv
// cr_sched_pkg: shared sizing constants and helpers for the transmit scheduler.
package cr_sched_pkg;
    function automatic int clog2(input int v);
        return (v <= 1) ? 0 : $clog2(v);
    endfunction
    localparam int FLOW_ID_W = 10;
    localparam int FLOW_CNT  = 1024;
    localparam int FID_NONE  = 0;
    localparam int OCC_W     = clog2(FLOW_CNT) + 1;
endpackage

// File: rtl/fid_ring_2w1r.sv
// fid_ring_2w1r: 2-write/1-read flow ID ring with head/tail pointers.
module fid_ring_2w1r
    import cr_sched_pkg::*;
#(
    parameter int ID_W = FLOW_ID_W,
    parameter int CNT  = FLOW_CNT,
    localparam int PW  = clog2(CNT)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_wr_a_en,
    input  logic [ID_W-1:0] i_wr_a,
    input  logic            i_wr_b_en,
    input  logic [ID_W-1:0] i_wr_b,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_head
);
    logic [ID_W-1:0] r_mem [CNT];
    logic [PW-1:0]   r_head, r_tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_pop) r_head <= r_head + PW'(1);
            r_tail <= r_tail + PW'(i_wr_a_en) + PW'(i_wr_b_en);
        end
    end

    // Port b only fires together with port a, so it always lands at tail+1.
    always_ff @(posedge clk) begin
        if (i_wr_a_en) r_mem[r_tail] <= i_wr_a;
        if (i_wr_b_en) r_mem[r_tail + PW'(1)] <= i_wr_b;
    end

    assign o_head = r_mem[r_head];
endmodule

// File: rtl/cr_tx_sched.sv
// cr_tx_sched: duplicate-free round-robin transmit scheduler (two ready inputs, one issue per cycle).
// Define CR_TX_SCHED_STATS_EN to add saturating issued/dup-drop counters.
module cr_tx_sched
    import cr_sched_pkg::*;
#(
    parameter int ID_W  = FLOW_ID_W,
    parameter int CNT   = FLOW_CNT,
    localparam int OW   = clog2(CNT) + 1
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] rdy_fid1_in,
    input  logic [ID_W-1:0] rdy_fid2_in,
    input  logic            tx_grant_in,
    output logic [ID_W-1:0] tx_fid_out,
    output logic [OW-1:0]   occupancy_out,
    output logic            dup_drop_out,
    output logic            overflow_err_out
`ifdef CR_TX_SCHED_STATS_EN
    ,
    output logic [31:0]     issued_cnt_out,
    output logic [31:0]     dup_cnt_out
`endif
);
    localparam logic [ID_W-1:0] L_NONE = ID_W'(FID_NONE);

    logic [CNT-1:0]  r_inq;
    logic [OW-1:0]   r_occ;
    logic [ID_W-1:0] w_head;
    logic w_pop, w_same, w_q1, w_q2, w_v1, w_v2, w_d1, w_d2, w_ok1, w_ok2;

    assign w_pop  = tx_grant_in && (r_occ != '0);
    // The flow leaving this cycle counts as not queued, so it can be re-fed at once.
    assign w_q1   = r_inq[rdy_fid1_in] && !(w_pop && w_head == rdy_fid1_in);
    assign w_q2   = r_inq[rdy_fid2_in] && !(w_pop && w_head == rdy_fid2_in);
    assign w_same = rdy_fid2_in == rdy_fid1_in;
    assign w_v1   = (rdy_fid1_in != L_NONE) && !w_q1;
    assign w_d1   = (rdy_fid1_in != L_NONE) && w_q1;
    assign w_v2   = (rdy_fid2_in != L_NONE) && !w_same && !w_q2;
    assign w_d2   = (rdy_fid2_in != L_NONE) && !w_same && w_q2;
    assign w_ok1  = w_v1 && (r_occ < OW'(CNT));
    assign w_ok2  = w_v2 && ((r_occ + OW'(w_ok1)) < OW'(CNT));

    fid_ring_2w1r #(.ID_W(ID_W), .CNT(CNT)) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_a_en (w_ok1 | w_ok2),
        .i_wr_a    (w_ok1 ? rdy_fid1_in : rdy_fid2_in),
        .i_wr_b_en (w_ok1 & w_ok2),
        .i_wr_b    (rdy_fid2_in),
        .i_pop     (w_pop),
        .o_head    (w_head)
    );

    // Set after clear: a flow popped and re-pushed in one cycle stays marked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inq            <= '0;
            r_occ            <= '0;
            tx_fid_out       <= L_NONE;
            dup_drop_out     <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            r_occ        <= r_occ + OW'(w_ok1) + OW'(w_ok2) - OW'(w_pop);
            tx_fid_out   <= w_pop ? w_head : L_NONE;
            dup_drop_out <= w_d1 | w_d2;
            if ((w_v1 && !w_ok1) || (w_v2 && !w_ok2)) overflow_err_out <= 1'b1;
            if (w_pop) r_inq[w_head] <= 1'b0;
            if (w_ok1) r_inq[rdy_fid1_in] <= 1'b1;
            if (w_ok2) r_inq[rdy_fid2_in] <= 1'b1;
        end
    end

    assign occupancy_out = r_occ;

`ifdef CR_TX_SCHED_STATS_EN
    logic [31:0] w_dsum;
    assign w_dsum = 32'(w_d1) + 32'(w_d2);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_cnt_out <= '0;
            dup_cnt_out    <= '0;
        end else begin
            if (w_pop && issued_cnt_out != '1) issued_cnt_out <= issued_cnt_out + 32'd1;
            dup_cnt_out <= (dup_cnt_out > ~w_dsum) ? '1 : dup_cnt_out + w_dsum;
        end
    end
`endif
endmodule

// File: doc/cr_tx_sched.md
Name: cr_tx_sched

Overview:
- Transmit scheduler for the window-based credit engine core.
- Collects flow IDs the core reports as newly ready (two per cycle) and holds them in a duplicate-free FIFO ring.
- Issues at most one flow ID per cycle on the core's transmit-flow input, round-robin in arrival order.
- Sits between the core's ready outputs and its transmit-flow input; owns the fairness and sequencing policy for the transmit pipeline.

Parameters:
- FLOW_ID_W, 10, flow ID width.
- FLOW_CNT, 1024, number of flows; also the ring depth, so a flow occupies at most one slot.
- FID_NONE, 0, reserved "no flow" encoding; never enqueued.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rdy_fid1_in  in  FLOW_ID_W  ready flow from the enqueue path; FID_NONE = none
- rdy_fid2_in  in  FLOW_ID_W  ready flow from the transmit re-feed path; FID_NONE = none
- tx_grant_in  in  1  core can accept a transmit flow this cycle
- tx_fid_out  out  FLOW_ID_W  flow to transmit, registered; FID_NONE when idle
- occupancy_out  out  clog2(FLOW_CNT)+1  number of queued flows, registered
- dup_drop_out  out  1  one-cycle pulse when an input flow was already queued
- overflow_err_out  out  1  sticky; a push was attempted while the ring was full

Behaviour:
- Reset values: tx_fid_out=FID_NONE, occupancy_out=0, dup_drop_out=0, overflow_err_out=0; head/tail pointers=0; in_queue bitmap (FLOW_CNT bits) all 0.
- Reset asserted mid-operation discards all queued flows; the first output after release is FID_NONE.
- Push qualification, per input:
  - push if fid != FID_NONE and in_queue[fid]==0;
  - if fid != FID_NONE and in_queue[fid]==1: no push, pulse dup_drop_out.
- Ordering: fid1 is written before fid2 in the same cycle (fid1 at tail, fid2 at tail+1).
- Same fid on both inputs: pushed once, as fid1; no dup pulse.
- Pushing sets in_queue[fid]; the tail advances by the number pushed (0/1/2).
- Pop: when tx_grant_in=1 and occupancy>0 at the edge:
  - tx_fid_out <= ring[head];
  - head advances by 1;
  - in_queue[ring[head]] cleared.
  - Otherwise tx_fid_out <= FID_NONE.
- Latency: a flow pushed at edge N can be popped at edge N+1 at the earliest (visible on tx_fid_out after N+1). There is no same-cycle bypass.
- Empty ring with tx_grant_in=1: output FID_NONE, no state change.
- Pop and push of the same fid in one cycle: the bitmap push-set wins over the pop-clear, so the flow is re-queued at the tail. This is required for continuous flows.
- occupancy_next = occupancy + pushes − pop, computed at full width.
- Full ring: pushes beyond FLOW_CNT are dropped and overflow_err_out set. This is unreachable with correct dedup, so it is a bug detector only.
- Pointer wrap: pointers are log2(FLOW_CNT) bits and wrap modulo FLOW_CNT. FLOW_CNT must be a power of 2.
- The ring uses two write ports and one read port. The read data is registered directly into tx_fid_out.

Optional Feature:
- Macro CR_TX_SCHED_STATS_EN.
- Defined: adds 32-bit outputs issued_cnt_out (increments per non-NONE tx_fid_out) and dup_cnt_out (increments per dup drop, +2 if both inputs drop).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package cr_sched_pkg: FLOW_ID_W, FLOW_CNT, FID_NONE, occupancy width, clog2 helper.
- One sub-module, fid_ring_2w1r: a 2-write/1-read ring holding FLOW_CNT × FLOW_ID_W storage plus head/tail pointers.
- The bitmap, dedup, qualification and stats stay in cr_tx_sched.

Test Plan:
- Basic order: push 5 (fid1) and 7 (fid2) in one cycle, grant held high → tx_fid_out = 5, then 7, then FID_NONE; occupancy 2→1→0.
- Dedup: push 5; next cycle push 5 on fid1 while the ring holds it → dup_drop_out pulses once, occupancy stays 1, 5 issued once.
- Re-queue: flow 9 alone, grant high, rdy_fid2_in=9 every cycle → tx_fid_out=9 every cycle from edge 2; occupancy stays 1; no dup pulses.
- Backpressure: push 1,2,3 with grant low for 4 cycles → tx_fid_out FID_NONE; raise grant → 1,2,3 in order.
- Wrap: FLOW_CNT=8, cycle 20 distinct pushes/pops across the pointer wrap → FIFO order kept, overflow_err_out stays 0; reset mid-stream → outputs return to reset values and the bitmap is clear (a re-pushed fid is accepted).
